// File: rtl/y86_pkg.sv
// Shared Y86-64 execute-stage definitions: condition-function codes, ALU op
// encodings and the condition-code register layout.
package y86_pkg;

    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } cc_t;

    localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

endpackage

// File: rtl/exec_cc_stage_if.sv
// Handshake bundle between the ALU, the execute back end and the memory stage.
interface exec_cc_stage_if #(
    parameter int W = 64
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic         alu_op;
    logic [W-1:0] alu_out;
    logic         set_cc;
    logic [3:0]   ifun;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_cnd;

    modport master (
        output in_valid, alu_a, alu_b, alu_op, alu_out, set_cc, ifun, flush, out_ready,
        input  in_ready, out_valid, out_result, out_cnd
    );

    modport slave (
        input  in_valid, alu_a, alu_b, alu_op, alu_out, set_cc, ifun, flush, out_ready,
        output in_ready, out_valid, out_result, out_cnd
    );
endinterface

// File: rtl/exec_cond_eval.sv
// Combinational jXX/cmovXX condition evaluation from the condition-code register.
module exec_cond_eval
    import y86_pkg::*;
(
    input  cc_t        cc,
    input  logic [3:0] ifun,
    output logic       cnd
);

    always_comb begin
        // NOTE: default assigned first so no path through the case leaves cnd unassigned (no latch).
        cnd = 1'b0;
        case (ifun)
            C_YES:   cnd = 1'b1;
            C_LE:    cnd = (cc.sf ^ cc.of) | cc.zf;
            C_L:     cnd = cc.sf ^ cc.of;
            C_E:     cnd = cc.zf;
            C_NE:    cnd = ~cc.zf;
            C_GE:    cnd = ~(cc.sf ^ cc.of);
            C_G:     cnd = ~(cc.sf ^ cc.of) & ~cc.zf;
            default: cnd = 1'b0;
        endcase
    end

endmodule

// File: rtl/exec_cc_stage.sv
// Execute-stage back end: flag derivation, Y86-64 condition-code register,
// condition evaluation and a 2-entry skid buffer towards the memory stage.
module exec_cc_stage
    import y86_pkg::*;
#(
    parameter int W     = 64,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    exec_cc_stage_if.slave  bus,
    output logic            cc_zf,
    output logic            cc_sf,
    output logic            cc_of
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } occ_t;

    occ_t         state_q, state_d;
    logic [1:0]   occ_d;
    logic         in_ready_q;
    cc_t          cc_q, flags_n;
    logic         cnd_n;
    logic         accept, pop;
    logic         head_load, head_shift, tail_load;
    logic [W-1:0] head_result, tail_result;
    logic         head_cnd, tail_cnd;

    assign accept = bus.in_valid & in_ready_q;
    assign pop    = bus.out_valid & bus.out_ready;

    // Overflow is judged on sign bits only: same-sign add or opposite-sign sub flipping sign.
    always_comb begin
        flags_n.zf = (bus.alu_out == '0);
        flags_n.sf = bus.alu_out[W-1];
        if (bus.alu_op == ALU_ADD)
            flags_n.of = (bus.alu_a[W-1] == bus.alu_b[W-1]) && (bus.alu_out[W-1] != bus.alu_a[W-1]);
        else
            flags_n.of = (bus.alu_a[W-1] != bus.alu_b[W-1]) && (bus.alu_out[W-1] != bus.alu_a[W-1]);
    end

    // Condition is taken from the registered CC, i.e. before this instruction's update.
    exec_cond_eval u_cond (
        .cc   (cc_q),
        .ifun (bus.ifun),
        .cnd  (cnd_n)
    );

    always_comb begin
        state_d    = state_q;
        head_load  = 1'b0;
        head_shift = 1'b0;
        tail_load  = 1'b0;
        if (bus.flush) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: if (accept) begin
                    state_d   = S_ONE;
                    head_load = 1'b1;
                end
                S_ONE: begin
                    if (accept && pop) begin
                        head_load = 1'b1;
                    end else if (accept) begin
                        state_d   = S_FULL;
                        tail_load = 1'b1;
                    end else if (pop) begin
                        state_d = S_EMPTY;
                    end
                end
                S_FULL: if (pop) begin
                    state_d    = S_ONE;
                    head_shift = 1'b1;
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    assign occ_d = state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q     <= S_EMPTY;
            in_ready_q  <= 1'b1;
            cc_q        <= CC_RESET;
            head_result <= '0;
            head_cnd    <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= ({30'd0, occ_d} < 32'(DEPTH));
            if (accept && bus.set_cc && !bus.flush)
                cc_q <= flags_n;
            if (head_load) begin
                head_result <= bus.alu_out;
                head_cnd    <= cnd_n;
            end else if (head_shift) begin
                head_result <= tail_result;
                head_cnd    <= tail_cnd;
            end
        end
    end

    // NOTE: the second entry is storage only, never observed before being written, so it has no reset.
    always_ff @(posedge clk) begin
        if (tail_load) begin
            tail_result <= bus.alu_out;
            tail_cnd    <= cnd_n;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = (state_q != S_EMPTY);
    assign bus.out_result = head_result;
    assign bus.out_cnd    = head_cnd;
    assign cc_zf          = cc_q.zf;
    assign cc_sf          = cc_q.sf;
    assign cc_of          = cc_q.of;

endmodule

// File: tb/tb_exec_cc_stage.sv
// Directed self-checking bench for exec_cc_stage: flags, CC register, conditions,
// backpressure, flush and asynchronous reset.
module tb_exec_cc_stage;
    import y86_pkg::*;

    localparam int W = 64;
    localparam logic [W-1:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [W-1:0] MINN = 64'h8000_0000_0000_0000;

    logic clk = 1'b0;
    logic rst_n;
    logic cc_zf, cc_sf, cc_of;
    int   checks = 0;
    int   errors = 0;

    exec_cc_stage_if #(.W(W)) bus ();

    exec_cc_stage #(.W(W), .DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .cc_zf (cc_zf),
        .cc_sf (cc_sf),
        .cc_of (cc_of)
    );

    always #5 clk = ~clk;

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.alu_a    = '0;
        bus.alu_b    = '0;
        bus.alu_op   = ALU_ADD;
        bus.alu_out  = '0;
        bus.set_cc   = 1'b0;
        bus.ifun     = C_YES;
        bus.flush    = 1'b0;
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                         input logic [W-1:0] res, input logic sc, input logic [3:0] fn);
        bus.in_valid = 1'b1;
        bus.alu_a    = a;
        bus.alu_b    = b;
        bus.alu_op   = op;
        bus.alu_out  = res;
        bus.set_cc   = sc;
        bus.ifun     = fn;
    endtask

    // Presents one transaction for a single cycle; returns on the following falling edge.
    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                        input logic [W-1:0] res, input logic sc, input logic [3:0] fn);
        drive(a, b, op, res, sc, fn);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        idle();
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if ({bus.out_valid, bus.out_cnd, bus.in_ready} !== 3'b001) begin
            errors++; $display("FAIL reset_handshake got v/c/r=%b exp 001", {bus.out_valid, bus.out_cnd, bus.in_ready}); end
        checks++; if (bus.out_result !== '0) begin
            errors++; $display("FAIL reset_result got %h exp 0", bus.out_result); end
        checks++; if ({cc_zf, cc_sf, cc_of} !== 3'b100) begin
            errors++; $display("FAIL reset_cc got %b exp 100", {cc_zf, cc_sf, cc_of}); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_sub_zero();
        drain();
        push(64'd1, 64'd1, ALU_ADD, 64'd2, 1'b1, C_YES);
        checks++; if ({bus.out_valid, bus.out_result, bus.out_cnd} !== {1'b1, 64'd2, 1'b1}) begin
            errors++; $display("FAIL add_1_1_out got v=%b r=%h c=%b exp v=1 r=2 c=1", bus.out_valid, bus.out_result, bus.out_cnd); end
        checks++; if ({cc_zf, cc_sf, cc_of} !== 3'b000) begin
            errors++; $display("FAIL add_1_1_cc got %b exp 000", {cc_zf, cc_sf, cc_of}); end
        push(64'd5, 64'd5, ALU_SUB, 64'd0, 1'b1, C_LE);
        checks++; if ({bus.out_valid, bus.out_result, bus.out_cnd} !== {1'b1, 64'd0, 1'b0}) begin
            errors++; $display("FAIL sub_5_5_out got v=%b r=%h c=%b exp v=1 r=0 c=0", bus.out_valid, bus.out_result, bus.out_cnd); end
        checks++; if ({cc_zf, cc_sf, cc_of} !== 3'b100) begin
            errors++; $display("FAIL sub_5_5_cc got %b exp 100", {cc_zf, cc_sf, cc_of}); end
        push(64'd9, 64'd4, ALU_SUB, 64'd5, 1'b0, C_LE);
        checks++; if ({bus.out_result, bus.out_cnd} !== {64'd5, 1'b1}) begin
            errors++; $display("FAIL cmovle_after_zero got r=%h c=%b exp r=5 c=1", bus.out_result, bus.out_cnd); end
        checks++; if ({cc_zf, cc_sf, cc_of} !== 3'b100) begin
            errors++; $display("FAIL no_setcc_hold got %b exp 100", {cc_zf, cc_sf, cc_of}); end
        push(64'd0, 64'd0, ALU_ADD, 64'd0, 1'b0, C_E);
        checks++; if (bus.out_cnd !== 1'b1) begin
            errors++; $display("FAIL je_zero got %b exp 1", bus.out_cnd); end
        push(64'd0, 64'd0, ALU_ADD, 64'd0, 1'b0, C_NE);
        checks++; if (bus.out_cnd !== 1'b0) begin
            errors++; $display("FAIL jne_zero got %b exp 0", bus.out_cnd); end
    endtask

    task automatic test_add_overflow();
        drain();
        push(MAXP, 64'd1, ALU_ADD, MINN, 1'b1, C_YES);
        checks++; if ({bus.out_valid, bus.out_result} !== {1'b1, MINN}) begin
            errors++; $display("FAIL add_ovf_out got v=%b r=%h exp v=1 r=%h", bus.out_valid, bus.out_result, MINN); end
        checks++; if ({cc_zf, cc_sf, cc_of} !== 3'b011) begin
            errors++; $display("FAIL add_ovf_cc got %b exp 011", {cc_zf, cc_sf, cc_of}); end
        push(64'd0, 64'd0, ALU_ADD, 64'd0, 1'b0, C_L);
        checks++; if (bus.out_cnd !== 1'b0) begin
            errors++; $display("FAIL jl_after_ovf got %b exp 0", bus.out_cnd); end
        push(64'd0, 64'd0, ALU_ADD, 64'd0, 1'b0, C_GE);
        checks++; if (bus.out_cnd !== 1'b1) begin
            errors++; $display("FAIL jge_after_ovf got %b exp 1", bus.out_cnd); end
        push(64'd0, 64'd0, ALU_ADD, 64'd0, 1'b0, C_G);
        checks++; if (bus.out_cnd !== 1'b1) begin
            errors++; $display("FAIL jg_after_ovf got %b exp 1", bus.out_cnd); end
        push(64'd0, 64'd0, ALU_ADD, 64'd0, 1'b0, 4'h7);
        checks++; if (bus.out_cnd !== 1'b0) begin
            errors++; $display("FAIL ifun7 got %b exp 0", bus.out_cnd); end
        push(64'd0, 64'd0, ALU_ADD, 64'd0, 1'b0, 4'hF);
        checks++; if (bus.out_cnd !== 1'b0) begin
            errors++; $display("FAIL ifun15 got %b exp 0", bus.out_cnd); end
    endtask

    task automatic test_sub_overflow();
        drain();
        push(64'd5, 64'd5, ALU_SUB, 64'd0, 1'b1, C_YES);
        push(MINN, 64'd1, ALU_SUB, MAXP, 1'b0, C_YES);
        checks++; if ({cc_zf, cc_sf, cc_of} !== 3'b100) begin
            errors++; $display("FAIL sub_ovf_nosetcc got %b exp 100", {cc_zf, cc_sf, cc_of}); end
        push(MINN, 64'd1, ALU_SUB, MAXP, 1'b1, C_YES);
        checks++; if (bus.out_result !== MAXP) begin
            errors++; $display("FAIL sub_ovf_out got %h exp %h", bus.out_result, MAXP); end
        checks++; if ({cc_zf, cc_sf, cc_of} !== 3'b001) begin
            errors++; $display("FAIL sub_ovf_cc got %b exp 001", {cc_zf, cc_sf, cc_of}); end
        push(64'd0, 64'd0, ALU_ADD, 64'd0, 1'b0, C_L);
        checks++; if (bus.out_cnd !== 1'b1) begin
            errors++; $display("FAIL jl_after_subovf got %b exp 1", bus.out_cnd); end
        push(64'd0, 64'd0, ALU_ADD, 64'd0, 1'b0, C_LE);
        checks++; if (bus.out_cnd !== 1'b1) begin
            errors++; $display("FAIL jle_after_subovf got %b exp 1", bus.out_cnd); end
    endtask

    task automatic test_back_to_back();
        drain();
        bus.out_ready = 1'b0;
        drive(64'h10, 64'h01, ALU_ADD, 64'h11, 1'b0, C_YES);
        @(negedge clk);
        checks++; if ({bus.in_ready, bus.out_valid, bus.out_result} !== {2'b11, 64'h11}) begin
            errors++; $display("FAIL bp_first got rdy=%b v=%b r=%h exp 1 1 11", bus.in_ready, bus.out_valid, bus.out_result); end
        drive(64'h20, 64'h02, ALU_ADD, 64'h22, 1'b0, 4'h7);
        @(negedge clk);
        checks++; if ({bus.in_ready, bus.out_result} !== {1'b0, 64'h11}) begin
            errors++; $display("FAIL bp_full got rdy=%b r=%h exp 0 11", bus.in_ready, bus.out_result); end
        drive(64'h30, 64'h03, ALU_ADD, 64'h33, 1'b0, C_YES);
        @(negedge clk);
        checks++; if ({bus.in_ready, bus.out_valid, bus.out_result, bus.out_cnd} !== {2'b01, 64'h11, 1'b1}) begin
            errors++; $display("FAIL bp_hold got rdy=%b v=%b r=%h c=%b exp 0 1 11 1", bus.in_ready, bus.out_valid, bus.out_result, bus.out_cnd); end
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++; if ({bus.in_ready, bus.out_result, bus.out_cnd} !== {1'b1, 64'h22, 1'b0}) begin
            errors++; $display("FAIL bp_pop1 got rdy=%b r=%h c=%b exp 1 22 0", bus.in_ready, bus.out_result, bus.out_cnd); end
        @(negedge clk);
        checks++; if ({bus.out_valid, bus.out_result, bus.out_cnd} !== {1'b1, 64'h33, 1'b1}) begin
            errors++; $display("FAIL bp_third got v=%b r=%h c=%b exp 1 33 1", bus.out_valid, bus.out_result, bus.out_cnd); end
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++; if ({bus.out_valid, bus.out_result} !== {1'b0, 64'h33}) begin
            errors++; $display("FAIL bp_empty_retain got v=%b r=%h exp 0 33", bus.out_valid, bus.out_result); end
    endtask

    task automatic test_flush();
        drain();
        push(64'd5, 64'd5, ALU_SUB, 64'd0, 1'b1, C_YES);
        bus.out_ready = 1'b0;
        push(64'd1, 64'd1, ALU_ADD, 64'd2, 1'b0, C_YES);
        push(64'd2, 64'd2, ALU_ADD, 64'd4, 1'b0, C_YES);
        drive(MAXP, 64'd1, ALU_ADD, MINN, 1'b1, C_YES);
        bus.flush = 1'b1;
        @(negedge clk);
        idle();
        checks++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            errors++; $display("FAIL flush_full got v=%b rdy=%b exp 0 1", bus.out_valid, bus.in_ready); end
        checks++; if ({cc_zf, cc_sf, cc_of} !== 3'b100) begin
            errors++; $display("FAIL flush_full_cc got %b exp 100", {cc_zf, cc_sf, cc_of}); end
        push(64'd3, 64'd3, ALU_ADD, 64'd6, 1'b0, C_YES);
        bus.out_ready = 1'b1;
        drive(MAXP, 64'd1, ALU_ADD, MINN, 1'b1, C_YES);
        bus.flush = 1'b1;
        @(negedge clk);
        idle();
        checks++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            errors++; $display("FAIL flush_accept got v=%b rdy=%b exp 0 1", bus.out_valid, bus.in_ready); end
        checks++; if ({cc_zf, cc_sf, cc_of} !== 3'b100) begin
            errors++; $display("FAIL flush_accept_cc got %b exp 100", {cc_zf, cc_sf, cc_of}); end
        push(64'h40, 64'h04, ALU_ADD, 64'h44, 1'b0, C_E);
        checks++; if ({bus.out_valid, bus.out_result, bus.out_cnd} !== {1'b1, 64'h44, 1'b1}) begin
            errors++; $display("FAIL after_flush got v=%b r=%h c=%b exp 1 44 1", bus.out_valid, bus.out_result, bus.out_cnd); end
    endtask

    task automatic test_reset_midburst();
        drain();
        bus.out_ready = 1'b0;
        push(MAXP, 64'd1, ALU_ADD, MINN, 1'b1, C_YES);
        push(64'd7, 64'd1, ALU_ADD, 64'd8, 1'b0, C_YES);
        checks++; if ({bus.in_ready, cc_zf, cc_sf, cc_of} !== 4'b0011) begin
            errors++; $display("FAIL pre_reset got rdy/cc=%b exp 0011", {bus.in_ready, cc_zf, cc_sf, cc_of}); end
        rst_n = 1'b0;
        #1;
        checks++; if ({bus.out_valid, bus.in_ready, cc_zf, cc_sf, cc_of} !== 5'b01100) begin
            errors++; $display("FAIL async_reset got v/rdy/cc=%b exp 01100", {bus.out_valid, bus.in_ready, cc_zf, cc_sf, cc_of}); end
        checks++; if ({bus.out_result, bus.out_cnd} !== {64'd0, 1'b0}) begin
            errors++; $display("FAIL async_reset_out got r=%h c=%b exp 0 0", bus.out_result, bus.out_cnd); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            errors++; $display("FAIL post_reset got v=%b rdy=%b exp 0 1", bus.out_valid, bus.in_ready); end
    endtask

    initial begin
        bus.out_ready = 1'b1;
        test_reset();
        test_sub_zero();
        test_add_overflow();
        test_sub_overflow();
        test_back_to_back();
        test_flush();
        test_reset_midburst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
